axis_interconnect_rr: RTL and testbench

- Parametrised N-to-1 AXI-Stream style interconnect that merges NUM_CH source streams onto one sink port.
- Arbitration is selectable: round-robin or fixed-priority.
- Optional packet mode holds a grant until the source's last beat.
- A registered 2-entry skid buffer on the output breaks the p_ready combinational path.
- Sits between the per-stage image processing producers and the single DMA/output consumer.

---
 rtl/axis_ic_pkg.sv | 28 ++
 rtl/axis_skid_buffer.sv | 54 +++++
 rtl/axis_interconnect_rr.sv | 122 ++++++++++++
 tb/tb_axis_interconnect_rr.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_ic_pkg.sv
// axis_ic_pkg: shared types and helpers for the AXI-Stream N-to-1 interconnect.
// Holds FSM state encodings, a clog2 helper and the skid entry layout {src, last, data}.
package axis_ic_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } ic_state_t;

    function automatic int ic_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Skid entry layout, LSB first: data, then last, then src.
    function automatic int ic_entry_w(input int dw, input int cw);
        return dw + 1 + cw;
    endfunction

    function automatic int ic_last_pos(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry registered FIFO for valid/ready streams.
// Ports: in_valid/in_ready/in_data (push side), out_valid/out_ready/out_data (pop side).
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd;
    logic             r_wr;
    logic [1:0]       r_cnt;
    logic             r_not_full;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_cnt_nxt;

    assign w_push    = in_valid & r_not_full;
    assign w_pop     = (r_cnt != 2'd0) & out_ready;
    assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

    // in_ready comes from a flop so it never depends on out_ready.
    assign in_ready  = r_not_full;
    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_cnt      <= 2'd0;
            r_not_full <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= in_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_cnt      <= w_cnt_nxt;
            r_not_full <= (w_cnt_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/axis_interconnect_rr.sv
// axis_interconnect_rr: NUM_CH-to-1 stream merger, round-robin or fixed priority,
// optional packet-hold grant. Ports: d_valid/last_in/data_in/i_ready per channel,
// p_ready sink ready, d_valid_out/data_out/last_out/src_out registered output beat.
module axis_interconnect_rr
    import axis_ic_pkg::*;
#(
    parameter int  NUM_CH      = 15,
    parameter int  DATA_W      = 32,
    parameter int  RR_MODE     = 1,
    parameter int  PACKET_MODE = 0,
    localparam int CH_W        = ic_clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        d_valid,
    input  logic [NUM_CH-1:0]        last_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH-1:0]        i_ready,
    input  logic                     p_ready,
    output logic                     d_valid_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     last_out,
    output logic [CH_W-1:0]          src_out
);

    localparam int EW = ic_entry_w(DATA_W, CH_W);

    ic_state_t        r_state;
    ic_state_t        w_state_nxt;
    logic [CH_W-1:0]  r_grant;
    logic [CH_W-1:0]  w_grant_nxt;
    logic [CH_W-1:0]  r_rr_ptr;
    logic [CH_W-1:0]  w_rr_ptr_nxt;
    logic [CH_W-1:0]  w_winner;
    logic             w_found;
    int               w_base;
    int               w_idx;

    logic             w_skid_rdy;
    logic             w_skid_vld;
    logic             w_push;
    logic             w_beat_last;
    logic [DATA_W-1:0] w_beat_data;
    logic [EW-1:0]    w_skid_in;
    logic [EW-1:0]    w_skid_out;

    // Search starts at the pointer and wraps explicitly at NUM_CH-1,
    // so non power-of-two channel counts never produce a stray index.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_base   = (RR_MODE != 0) ? int'(r_rr_ptr) : 0;
        w_idx    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = w_base + k;
            if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            if (!w_found && d_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = CH_W'(w_idx);
            end
        end
    end

    assign w_beat_data = data_in[int'(r_grant)*DATA_W +: DATA_W];
    assign w_beat_last = (PACKET_MODE != 0) ? last_in[r_grant] : 1'b1;
    assign w_skid_in   = {r_grant, w_beat_last, w_beat_data};
    assign w_skid_vld  = (r_state == ST_XFER) & d_valid[r_grant];
    assign w_push      = w_skid_vld & w_skid_rdy;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        i_ready      = '0;
        unique case (r_state)
            ST_ARB: begin
                if (w_found) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                i_ready[r_grant] = w_skid_rdy;
                if (w_push && ((PACKET_MODE == 0) || last_in[r_grant])) begin
                    w_state_nxt  = ST_ARB;
                    w_rr_ptr_nxt = (int'(r_grant) == NUM_CH - 1) ?
                                   '0 : r_grant + CH_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ARB;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    axis_skid_buffer #(
        .WIDTH(EW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (w_skid_vld),
        .in_ready (w_skid_rdy),
        .in_data  (w_skid_in),
        .out_valid(d_valid_out),
        .out_ready(p_ready),
        .out_data (w_skid_out)
    );

    assign data_out = w_skid_out[DATA_W-1:0];
    assign last_out = w_skid_out[ic_last_pos(DATA_W)];
    assign src_out  = w_skid_out[EW-1 -: CH_W];

endmodule

// File: tb/tb_axis_interconnect_rr.sv
// tb_axis_interconnect_rr: three interconnect configurations driven by shared
// stimulus, each compared cycle by cycle against a queue-based reference model.
module tb_axis_interconnect_rr;

    localparam int N  = 15;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [3:0]  s;
    } beat_t;

    localparam int RRM [3] = '{1, 1, 0};
    localparam int PKM [3] = '{0, 1, 0};

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    dv;
    logic [N-1:0]    lst;
    logic [N*DW-1:0] din;
    logic            pr;

    logic [N-1:0]    rdy [3];
    logic            ov  [3];
    logic [31:0]     od  [3];
    logic            ol  [3];
    logic [3:0]      os  [3];

    int    n_vec = 0;
    int    n_err = 0;
    int    m_busy  [3];
    int    m_grant [3];
    int    m_ptr   [3];
    bit    m_space [3];
    beat_t mq [3][$];
    int    pk_beats = 0;

    always #5 clk = ~clk;

    axis_interconnect_rr #(.NUM_CH(N), .DATA_W(DW), .RR_MODE(1), .PACKET_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .d_valid(dv), .last_in(lst), .data_in(din),
        .i_ready(rdy[0]), .p_ready(pr), .d_valid_out(ov[0]), .data_out(od[0]),
        .last_out(ol[0]), .src_out(os[0]));

    axis_interconnect_rr #(.NUM_CH(N), .DATA_W(DW), .RR_MODE(1), .PACKET_MODE(1)) u_pk (
        .clk(clk), .rst_n(rst_n), .d_valid(dv), .last_in(lst), .data_in(din),
        .i_ready(rdy[1]), .p_ready(pr), .d_valid_out(ov[1]), .data_out(od[1]),
        .last_out(ol[1]), .src_out(os[1]));

    axis_interconnect_rr #(.NUM_CH(N), .DATA_W(DW), .RR_MODE(0), .PACKET_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .d_valid(dv), .last_in(lst), .data_in(din),
        .i_ready(rdy[2]), .p_ready(pr), .d_valid_out(ov[2]), .data_out(od[2]),
        .last_out(ol[2]), .src_out(os[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k]  = 0;
            m_grant[k] = 0;
            m_ptr[k]   = 0;
            m_space[k] = 1'b1;
            mq[k].delete();
        end
    endtask

    task automatic model_tick(input int k);
        beat_t b;
        int    g;
        int    c;
        if (mq[k].size() > 0 && pr) b = mq[k].pop_front();
        if (m_busy[k] != 0) begin
            g = m_grant[k];
            if (m_space[k] && dv[g]) begin
                b.d = din[g*DW +: DW];
                b.l = (PKM[k] != 0) ? lst[g] : 1'b1;
                b.s = 4'(g);
                mq[k].push_back(b);
                if (k == 1 && g == 3) pk_beats++;
                if (PKM[k] == 0 || lst[g]) begin
                    m_busy[k] = 0;
                    m_ptr[k]  = (g + 1) % N;
                end
            end
        end else if (dv != '0) begin
            for (int j = 0; j < N; j++) begin
                c = (((RRM[k] != 0) ? m_ptr[k] : 0) + j) % N;
                if (m_busy[k] == 0 && dv[c]) begin
                    m_busy[k]  = 1;
                    m_grant[k] = c;
                end
            end
        end
        m_space[k] = (mq[k].size() < 2);
    endtask

    task automatic step();
        logic [N-1:0] er;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                chk($sformatf("rst_rdy%0d", k), 64'(rdy[k]), 64'd0);
                chk($sformatf("rst_vld%0d", k), 64'(ov[k]), 64'd0);
                chk($sformatf("rst_dat%0d", k), 64'(od[k]), 64'd0);
                chk($sformatf("rst_lst%0d", k), 64'(ol[k]), 64'd0);
                chk($sformatf("rst_src%0d", k), 64'(os[k]), 64'd0);
            end else begin
                er = (m_busy[k] != 0 && m_space[k]) ? N'(1 << m_grant[k]) : '0;
                chk($sformatf("rdy%0d", k), 64'(rdy[k]), 64'(er));
                chk($sformatf("vld%0d", k), 64'(ov[k]), 64'(mq[k].size() > 0));
                if (mq[k].size() > 0) begin
                    chk($sformatf("dat%0d", k), 64'(od[k]), 64'(mq[k][0].d));
                    chk($sformatf("lst%0d", k), 64'(ol[k]), 64'(mq[k][0].l));
                    chk($sformatf("src%0d", k), 64'(os[k]), 64'(mq[k][0].s));
                end
            end
        end
        if (!rst_n) model_reset();
        else for (int k = 0; k < 3; k++) model_tick(k);
        @(posedge clk);
        #1;
    endtask

    task automatic fixed_data();
        for (int i = 0; i < N; i++) din[i*DW +: DW] = 32'(i + 1);
    endtask

    initial begin
        rst_n = 1'b1;
        dv    = '0;
        lst   = '0;
        pr    = 1'b1;
        fixed_data();
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();

        // single source
        dv = 15'h0004;
        repeat (10) step();
        dv = '0;
        repeat (3) step();

        // two requesters alternate
        dv = 15'h0005;
        repeat (12) step();
        dv = '0;
        repeat (3) step();

        // backpressure
        dv = 15'h0002;
        pr = 1'b0;
        repeat (6) step();
        pr = 1'b1;
        repeat (6) step();
        dv = '0;
        repeat (4) step();

        // packet hold: ch3 sends 4 beats while ch5 waits
        dv = 15'h0028;
        pk_beats = 0;
        for (int c = 0; c < 20; c++) begin
            lst = (pk_beats == 3) ? 15'h0008 : '0;
            step();
        end
        dv  = '0;
        lst = '0;
        repeat (4) step();

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            dv  = N'($urandom) & N'($urandom);
            lst = N'($urandom) & N'($urandom);
            pr  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) din[i*DW +: DW] = $urandom;
            step();
        end

        // reset during a ch3 packet
        fixed_data();
        dv  = 15'h0008;
        lst = '0;
        pr  = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("arst_vld%0d", k), 64'(ov[k]), 64'd0);
            chk($sformatf("arst_rdy%0d", k), 64'(rdy[k]), 64'd0);
        end
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        dv = 15'h0108;
        repeat (8) step();
        dv = '0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
